aclint_memory: RTL and testbench
================================

Name: aclint_memory

Overview:
- Master (driving) end of the `aclint_if` that the CSR unit consumes as slave.
- Implements the machine-level ACLINT as a memory-mapped responder on the core's data-side bus:
  - 64-bit free-running `mtime` counter;
  - `mtimecmp` compare register;
  - MSIP software-interrupt register.
- Drives `mtip` and `msip` level outputs into `aclint_if`, which feed `mip[7]` and `mip[3]`.

Parameters:
- `BASE_ADDR`, 64'h0200_0000, byte base address of the ACLINT window.
- `ADDR_WIDTH`, 64, width of `req_addr`.
- `MTIME_DIV`, 1, clock cycles per `mtime` increment (1 = every cycle; legal 1..65535).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  bus request present.
- `req_ready`  out  1  request accepted this cycle.
- `req_addr`  in  ADDR_WIDTH  byte address; bits [2:0] ignored (8-byte aligned access).
- `req_wen`  in  1  1 = write, 0 = read.
- `req_wdata`  in  64  write data.
- `req_wmask`  in  8  byte enables for write (bit i → byte i).
- `rsp_valid`  out  1  response valid.
- `rsp_rdata`  out  64  read data (0 for writes and unmapped addresses).
- `aclint`  `aclint_if.master`  —  drives `mtip` and `msip`.

Behaviour:

Address map (offset = `req_addr - BASE_ADDR`, decoded on bits [15:3]):
- 0x0000 MSIP: bit0 is R/W; bits 63:1 read 0 and ignore writes.
- 0x4000 MTIMECMP: full 64-bit R/W.
- 0xBFF8 MTIME: 64-bit, read always; write only per the optional feature.
- Any other offset, or an address outside [BASE, BASE+0x10000): read returns 0, write is ignored, and a response is still given.

Handshake:
- `req_ready` is tied to 1; a request is accepted whenever `req_valid` = 1.
- Accepted request → `rsp_valid` = 1 exactly one cycle later, with `rsp_rdata` registered from the pre-write register values.
- There is no response backpressure. Back-to-back requests give back-to-back responses.
- Write effect is visible to a read issued the following cycle.
- Write mask: new byte i = `req_wmask[i]` ? `req_wdata` byte i : old byte i. A zero mask writes nothing.

`mtime` counter:
- Prescaler `div_cnt` counts 0..MTIME_DIV-1.
- `mtime` increments by 1 on the cycle `div_cnt` wraps to 0.
- `mtime` wraps from 2^64-1 to 0 with no flag.
- A bus write to MTIME in the same cycle as an increment: the write wins for enabled bytes. Disabled bytes take the incremented value.
- `div_cnt` is not affected by MTIME writes.

Interrupt outputs:
- `mtip`: a flop loaded every cycle with unsigned (`mtime` >= `mtimecmp`), using the current register values. It therefore lags a register change by 1 cycle and remains a level signal until the condition clears.
- `msip`: equals MSIP bit0, taken directly from the flop.

Reset (asynchronous, `rst` = 0):
- `mtime` = 0, `div_cnt` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, MSIP = 0.
- `mtip` = 0, `msip` = 0, `rsp_valid` = 0, `rsp_rdata` = 0.
- Reset mid-transaction drops any pending response (`rsp_valid` forced 0) and takes effect without waiting for `clk`.

Optional Feature:
- Macro `ACLINT_MTIME_WRITE_EN`.
- Defined: MTIME is writable with byte masks, with the write-vs-increment priority given above.
- Undefined: writes to MTIME are ignored; `mtime` only counts. The write still gets `rsp_valid` one cycle later.

Test Plan:
1. Reset release, MTIME_DIV = 1 → read MTIME at cycle N and again at N+5 → values differ by 5; `mtip` = 0 and `msip` = 0 throughout.
2. Write MTIMECMP = 20 with mask 8'hFF while `mtime` ≈ 10 → `mtip` rises exactly 1 cycle after `mtime` reaches 20. Then write MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF → `mtip` falls 2 cycles after the request.
3. Write MSIP with `wdata` = 64'hFFFF_FFFF_FFFF_FFFF, mask 8'h01 → `msip` = 1 the next cycle and a read returns 64'h1. Write 0 → `msip` = 0.
4. Partial write MTIMECMP with mask 8'h0F, `wdata` = 64'h1111_1111_2222_2222, over a prior value of 64'hAAAA_AAAA_BBBB_BBBB → read returns 64'hAAAA_AAAA_2222_2222.
5. With `ACLINT_MTIME_WRITE_EN`, write MTIME = 64'hFFFF_FFFF_FFFF_FFFE on an increment cycle → reads give FFFE, then FFFF, then 0 (wrap). Without the macro, the same write leaves the count sequence undisturbed.
6. Read offset 0x1000 → `rsp_rdata` = 0 and `rsp_valid` 1 cycle later. Assert `rst` = 0 while `rsp_valid` is pending → `rsp_valid` drops immediately and all registers return to their reset values.

Source files
------------

// File: rtl/aclint_if.sv
// Level interrupt lines from the ACLINT to the CSR unit (mtip -> mip[7], msip -> mip[3]).
interface aclint_if;
    logic mtip;
    logic msip;

    modport master (output mtip, output msip);
    modport slave  (input  mtip, input  msip);
endinterface

// File: rtl/aclint_memory.sv
// Machine-level ACLINT bus responder: free-running mtime, mtimecmp and MSIP, driving mtip/msip.
// Optional feature macro: ACLINT_MTIME_WRITE_EN (defined = MTIME writable with byte masks).
module aclint_memory #(
    parameter logic [63:0] BASE_ADDR  = 64'h0200_0000,
    parameter int          ADDR_WIDTH = 64,
    parameter int          MTIME_DIV  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_wen,
    input  logic [63:0]           req_wdata,
    input  logic [7:0]            req_wmask,
    output logic                  rsp_valid,
    output logic [63:0]           rsp_rdata,
    aclint_if.master              aclint
);

    localparam logic [ADDR_WIDTH-1:0] BASE_A       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [15:0]           DIV_LAST     = 16'(MTIME_DIV - 1);
    localparam logic [12:0]           IDX_MSIP     = 13'h0000;
    localparam logic [12:0]           IDX_MTIMECMP = 13'h0800;
    localparam logic [12:0]           IDX_MTIME    = 13'h17FF;

    logic [15:0] div_cnt_q,   div_cnt_d;
    logic [63:0] mtime_q,     mtime_d;
    logic [63:0] mtimecmp_q,  mtimecmp_d;
    logic        msip_q,      msip_d;
    logic        mtip_q,      mtip_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_window;
    logic [12:0]           word_idx;
    logic                  sel_msip, sel_mtimecmp, sel_mtime;
    logic                  tick;
    logic [63:0]           mtime_inc;
    logic [63:0]           wmask_bits;
    logic                  unused_addr_bits;

    // Lower address bits select bytes within the 8-byte word and are not decoded.
    assign offset           = req_addr - BASE_A;
    assign unused_addr_bits = ^offset[2:0];
    assign in_window        = (req_addr >= BASE_A) && ((offset >> 16) == '0);
    assign word_idx         = offset[15:3];

    assign sel_msip     = req_valid && in_window && (word_idx == IDX_MSIP);
    assign sel_mtimecmp = req_valid && in_window && (word_idx == IDX_MTIMECMP);
    assign sel_mtime    = req_valid && in_window && (word_idx == IDX_MTIME);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_wmask
            assign wmask_bits[gi*8 +: 8] = {8{req_wmask[gi]}};
        end
    endgenerate

    assign tick      = (div_cnt_q == DIV_LAST);
    assign mtime_inc = mtime_q + {63'd0, tick};

    always_comb begin
        div_cnt_d   = tick ? 16'd0 : div_cnt_q + 16'd1;
        mtime_d     = mtime_inc;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        mtip_d      = (mtime_q >= mtimecmp_q);
        rsp_valid_d = req_valid;
        rsp_rdata_d = 64'd0;

        if (req_wen) begin
            if (sel_mtimecmp) begin
                mtimecmp_d = (req_wdata & wmask_bits) | (mtimecmp_q & ~wmask_bits);
            end
            if (sel_msip && req_wmask[0]) begin
                msip_d = req_wdata[0];
            end
`ifdef ACLINT_MTIME_WRITE_EN
            // Bytes not enabled still carry this cycle's increment.
            if (sel_mtime) begin
                mtime_d = (req_wdata & wmask_bits) | (mtime_inc & ~wmask_bits);
            end
`endif
        end else begin
            if (sel_msip) begin
                rsp_rdata_d = {63'd0, msip_q};
            end else if (sel_mtimecmp) begin
                rsp_rdata_d = mtimecmp_q;
            end else if (sel_mtime) begin
                rsp_rdata_d = mtime_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q   <= 16'd0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            mtip_q      <= mtip_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready   = 1'b1;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign aclint.mtip = mtip_q;
    assign aclint.msip = msip_q;

endmodule

// File: tb/tb_aclint_memory.sv
// Self-checking bench for aclint_memory: scoreboard of expected responses plus per-feature tasks.
module tb_aclint_memory;

    localparam logic [63:0] BASE      = 64'h0200_0000;
    localparam logic [63:0] A_MSIP    = BASE;
    localparam logic [63:0] A_CMP     = BASE + 64'h4000;
    localparam logic [63:0] A_MTIME   = BASE + 64'hBFF8;
    localparam logic [63:0] ALL_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'd0;
    logic        req_wen = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_wmask = 8'd0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;

    aclint_if aclint_bus();

    aclint_memory #(
        .BASE_ADDR (BASE),
        .ADDR_WIDTH(64),
        .MTIME_DIV (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_wen  (req_wen),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .aclint   (aclint_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Posedges since reset release; equals the expected mtime when sampled at a negedge.
    logic [63:0] cyc = 64'd0;
    logic [63:0] off = 64'd0;
    always @(posedge clk) begin
        if (!rst) cyc <= 64'd0;
        else      cyc <= cyc + 64'd1;
    end

    logic [63:0] exp_q[$];
    logic [63:0] due_q[$];
    string       nm_q[$];

    function automatic logic [63:0] mt_now();
        return cyc + off;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] nw, input logic [63:0] old,
                                          input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = m[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    task automatic drive_req(input logic [63:0] addr, input logic wen, input logic [63:0] wd,
                             input logic [7:0] wm, input logic [63:0] exp, input string nm);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wd;
        req_wmask = wm;
        exp_q.push_back(exp);
        due_q.push_back(cyc + 64'd1);
        nm_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        req_wen   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        exp_q.delete();
        due_q.delete();
        nm_q.delete();
        off = 64'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic monitor();
        logic [63:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (due_q.size() != 0 && due_q[0] == cyc) begin
                    void'(due_q.pop_front());
                    e  = exp_q.pop_front();
                    nm = nm_q.pop_front();
                    total++;
                    if (rsp_valid !== 1'b1 || rsp_rdata !== e) begin
                        bad++;
                        $display("FAIL %s: rsp_valid=%b rsp_rdata=%h expected valid=1 rdata=%h",
                                 nm, rsp_valid, rsp_rdata, e);
                    end else begin
                        $display("ok   %s: rdata=%h", nm, rsp_rdata);
                    end
                end else if (rsp_valid !== 1'b0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_rsp: rsp_valid=%b expected 0 at cycle %0d", rsp_valid, cyc);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || aclint_bus.mtip !== 1'b0 || aclint_bus.msip !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b rdata=%h mtip=%b msip=%b expected all 0",
                     rsp_valid, rsp_rdata, aclint_bus.mtip, aclint_bus.msip);
        end
        rst = 1'b1;
        drive_req(A_MTIME, 1'b0, 64'd0, 8'd0, mt_now(), "reset_mtime");
        drive_req(A_CMP,   1'b0, 64'd0, 8'd0, ALL_ONES, "reset_mtimecmp");
        drive_req(A_MSIP,  1'b0, 64'd0, 8'd0, 64'd0,    "reset_msip");
        idle(2);
    endtask

    task automatic test_mtime_count();
        logic [63:0] first;
        do_reset();
        idle(4);
        first = mt_now();
        drive_req(A_MTIME, 1'b0, 64'd0, 8'd0, first, "mtime_n");
        idle(4);
        total++;
        if (mt_now() - first !== 64'd5) begin
            bad++;
            $display("FAIL mtime_gap: model gap %0d expected 5", mt_now() - first);
        end
        drive_req(A_MTIME, 1'b0, 64'd0, 8'd0, first + 64'd5, "mtime_n_plus_5");
        for (int k = 0; k < 4; k++) begin
            total++;
            if (aclint_bus.mtip !== 1'b0 || aclint_bus.msip !== 1'b0) begin
                bad++;
                $display("FAIL idle_irq: mtip=%b msip=%b expected 0 0", aclint_bus.mtip, aclint_bus.msip);
            end
            idle(1);
        end
    endtask

    task automatic test_mtip();
        do_reset();
        idle(8);
        drive_req(A_CMP, 1'b1, 64'd20, 8'hFF, 64'd0, "wr_mtimecmp_20");
        req_valid = 1'b0;
        for (int k = 0; k < 100 && cyc < 64'd20; k++) @(negedge clk);
        total++;
        if (cyc != 64'd20 || aclint_bus.mtip !== 1'b0) begin
            bad++;
            $display("FAIL mtip_at_match: cyc=%0d mtip=%b expected cyc=20 mtip=0", cyc, aclint_bus.mtip);
        end
        @(negedge clk);
        total++;
        if (aclint_bus.mtip !== 1'b1) begin
            bad++;
            $display("FAIL mtip_rise: mtip=%b expected 1", aclint_bus.mtip);
        end
        drive_req(A_CMP, 1'b1, ALL_ONES, 8'hFF, 64'd0, "wr_mtimecmp_max");
        total++;
        if (aclint_bus.mtip !== 1'b1) begin
            bad++;
            $display("FAIL mtip_hold: mtip=%b expected 1 one cycle after request", aclint_bus.mtip);
        end
        idle(1);
        total++;
        if (aclint_bus.mtip !== 1'b0) begin
            bad++;
            $display("FAIL mtip_fall: mtip=%b expected 0 two cycles after request", aclint_bus.mtip);
        end
        idle(1);
    endtask

    task automatic test_msip();
        drive_req(A_MSIP, 1'b1, ALL_ONES, 8'h01, 64'd0, "wr_msip_1");
        total++;
        if (aclint_bus.msip !== 1'b1) begin
            bad++;
            $display("FAIL msip_set: msip=%b expected 1", aclint_bus.msip);
        end
        drive_req(A_MSIP, 1'b0, 64'd0, 8'd0, 64'd1, "rd_msip_1");
        drive_req(A_MSIP, 1'b1, 64'd0, 8'hFE, 64'd0, "wr_msip_mask_fe");
        drive_req(A_MSIP, 1'b0, 64'd0, 8'd0, 64'd1, "rd_msip_still_1");
        drive_req(A_MSIP, 1'b1, 64'd0, 8'hFF, 64'd0, "wr_msip_0");
        total++;
        if (aclint_bus.msip !== 1'b0) begin
            bad++;
            $display("FAIL msip_clear: msip=%b expected 0", aclint_bus.msip);
        end
        idle(2);
    endtask

    task automatic test_partial_write();
        drive_req(A_CMP, 1'b1, 64'hAAAA_AAAA_BBBB_BBBB, 8'hFF, 64'd0, "wr_cmp_full");
        drive_req(A_CMP, 1'b1, 64'h1111_1111_2222_2222, 8'h0F, 64'd0, "wr_cmp_low");
        drive_req(A_CMP, 1'b0, 64'd0, 8'd0, 64'hAAAA_AAAA_2222_2222, "rd_cmp_partial");
        drive_req(A_CMP, 1'b1, 64'h5555_5555_5555_5555, 8'h00, 64'd0, "wr_cmp_zero_mask");
        drive_req(A_CMP, 1'b0, 64'd0, 8'd0, 64'hAAAA_AAAA_2222_2222, "rd_cmp_unchanged");
        drive_req(A_CMP, 1'b1, ALL_ONES, 8'hFF, 64'd0, "wr_cmp_restore");
        idle(2);
    endtask

    task automatic test_mtime_write();
`ifdef ACLINT_MTIME_WRITE_EN
        logic [63:0] nv;
        off = (64'hFFFF_FFFF_FFFF_FFFE) - (cyc + 64'd1);
`endif
        drive_req(A_MTIME, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0, "wr_mtime");
        drive_req(A_MTIME, 1'b0, 64'd0, 8'd0, mt_now(), "rd_mtime_a");
        drive_req(A_MTIME, 1'b0, 64'd0, 8'd0, mt_now(), "rd_mtime_b");
        drive_req(A_MTIME, 1'b0, 64'd0, 8'd0, mt_now(), "rd_mtime_wrap");
`ifdef ACLINT_MTIME_WRITE_EN
        total++;
        if (mt_now() !== 64'd1) begin
            bad++;
            $display("FAIL mtime_wrap_model: %h expected 1", mt_now());
        end
        nv  = merge(64'h0000_0000_0000_0040, mt_now() + 64'd1, 8'h01);
        off = nv - (cyc + 64'd1);
`endif
        drive_req(A_MTIME, 1'b1, 64'h0000_0000_0000_0040, 8'h01, 64'd0, "wr_mtime_byte0");
        drive_req(A_MTIME, 1'b0, 64'd0, 8'd0, mt_now(), "rd_mtime_after_byte0");
        idle(2);
    endtask

    task automatic test_back_to_back();
        drive_req(A_CMP,   1'b1, 64'h0000_1234_5678_9ABC, 8'hFF, 64'd0, "b2b_wr_cmp");
        drive_req(A_CMP,   1'b0, 64'd0, 8'd0, 64'h0000_1234_5678_9ABC, "b2b_rd_cmp");
        drive_req(A_MTIME, 1'b0, 64'd0, 8'd0, mt_now(), "b2b_rd_mtime_0");
        drive_req(A_MTIME, 1'b0, 64'd0, 8'd0, mt_now(), "b2b_rd_mtime_1");
        drive_req(A_MSIP,  1'b1, 64'd1, 8'h01, 64'd0, "b2b_wr_msip");
        drive_req(A_MSIP,  1'b0, 64'd0, 8'd0, 64'd1, "b2b_rd_msip");
        idle(2);
    endtask

    task automatic test_unmapped_and_reset();
        drive_req(A_CMP, 1'b1, 64'd0, 8'hFF, 64'd0, "wr_cmp_zero");
        drive_req(BASE + 64'h1000,  1'b0, 64'd0, 8'd0, 64'd0, "rd_hole_1000");
        drive_req(BASE - 64'd8,     1'b0, 64'd0, 8'd0, 64'd0, "rd_below_base");
        drive_req(BASE + 64'h14000, 1'b0, 64'd0, 8'd0, 64'd0, "rd_alias_above");
        drive_req(BASE + 64'h14000, 1'b1, 64'd5, 8'hFF, 64'd0, "wr_alias_above");
        drive_req(A_CMP, 1'b0, 64'd0, 8'd0, 64'd0, "rd_cmp_after_alias");
        idle(2);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = A_CMP;
        @(posedge clk);
        #2;
        total++;
        if (rsp_valid !== 1'b1 || aclint_bus.mtip !== 1'b1 || aclint_bus.msip !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_state: valid=%b mtip=%b msip=%b expected 1 1 1",
                     rsp_valid, aclint_bus.mtip, aclint_bus.msip);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || aclint_bus.mtip !== 1'b0 || aclint_bus.msip !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: valid=%b rdata=%h mtip=%b msip=%b expected all 0",
                     rsp_valid, rsp_rdata, aclint_bus.mtip, aclint_bus.msip);
        end
        @(negedge clk);
        do_reset();
        drive_req(A_CMP,   1'b0, 64'd0, 8'd0, ALL_ONES, "post_reset_cmp");
        drive_req(A_MSIP,  1'b0, 64'd0, 8'd0, 64'd0,    "post_reset_msip");
        drive_req(A_MTIME, 1'b0, 64'd0, 8'd0, mt_now(), "post_reset_mtime");
        idle(3);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_mtime_count();
        test_mtip();
        test_msip();
        test_partial_write();
        test_mtime_write();
        test_back_to_back();
        test_unmapped_and_reset();
        total++;
        if (due_q.size() != 0) begin
            bad++;
            $display("FAIL missing_rsp: %0d responses outstanding, expected 0", due_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
